// File: rtl/logic_accum_unit_if.sv
// Handshake bundle for logic_accum_unit: operand/op input channel and
// result output channel, each with its own valid/ready pair.
interface logic_accum_unit_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InA;
    logic [WIDTH-1:0] InB;
    logic [2:0]       Op;
    logic             InLast;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Out;
    logic             OutZero;
    logic [CNT_W-1:0] OutCount;

    modport slave (
        input  InValid, InA, InB, Op, InLast, OutReady,
        output InReady, OutValid, Out, OutZero, OutCount
    );

    modport master (
        output InValid, InA, InB, Op, InLast, OutReady,
        input  InReady, OutValid, Out, OutZero, OutCount
    );
endinterface

// File: rtl/logic_accum_unit.sv
// Registered bitwise AND/OR/XOR/NOR unit with multi-beat OR/AND reductions
// over InLast-delimited streams; one result per cycle under valid/ready flow.
module logic_accum_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic            Clk,
    input logic            Rst,
    logic_accum_unit_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_ACC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_and_q, acc_and_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_zero_q, out_zero_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic             in_ready;
    logic             accept;
    logic             fire;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] load_cnt;
    logic [WIDTH-1:0] bitwise_val;
    logic [WIDTH-1:0] fold_val;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready = !out_valid_q || bus.OutReady;
    assign accept   = bus.InValid && in_ready;
    assign fire     = out_valid_q && bus.OutReady;

    always_comb begin
        bitwise_val = '0;
        case (bus.Op[1:0])
            2'b00: bitwise_val = bus.InA & bus.InB;
            2'b01: bitwise_val = bus.InA | bus.InB;
            2'b10: bitwise_val = bus.InA ^ bus.InB;
            2'b11: bitwise_val = ~(bus.InA | bus.InB);
            default: bitwise_val = '0;
        endcase
    end

    // Only the AND/OR choice of the stream op matters once a stream is open.
    assign fold_val = acc_and_q ? (acc_q & bus.InA) : (acc_q | bus.InA);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_and_d   = acc_and_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_zero_d  = out_zero_q;
        out_count_d = out_count_q;
        load        = 1'b0;
        load_val    = '0;
        load_cnt    = CNT_W'(1);

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.Op[2]) begin
                        load     = 1'b1;
                        load_val = bitwise_val;
                    end else if (bus.Op[1]) begin
                        load     = 1'b1;
                        load_val = '0;
                    end else if (bus.InLast) begin
                        load     = 1'b1;
                        load_val = bus.InA;
                    end else begin
                        acc_d     = bus.InA;
                        cnt_d     = CNT_W'(1);
                        acc_and_d = bus.Op[0];
                        state_d   = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (bus.InLast) begin
                        load     = 1'b1;
                        load_val = fold_val;
                        load_cnt = cnt_inc;
                        state_d  = ST_IDLE;
                    end else begin
                        acc_d = fold_val;
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end

        // A new result wins over a simultaneous drain, giving back-to-back flow.
        if (load) begin
            out_valid_d = 1'b1;
            out_d       = load_val;
            out_zero_d  = (load_val == '0);
            out_count_d = load_cnt;
        end else if (fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            acc_and_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_zero_q  <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            acc_and_q   <= acc_and_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_zero_q  <= out_zero_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid_q;
    assign bus.Out      = out_q;
    assign bus.OutZero  = out_zero_q;
    assign bus.OutCount = out_count_q;
endmodule

// File: tb/tb_logic_accum_unit.sv
// Drives identical traffic into an 8-bit unit with an 8-bit and a 2-bit beat
// counter, checking both against a stream-level reference model every cycle.
module tb_logic_accum_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] op;

    logic_accum_unit_if #(.WIDTH(8), .CNT_W(8)) if8 ();
    logic_accum_unit_if #(.WIDTH(8), .CNT_W(2)) if2 ();

    assign if8.InValid  = in_valid;
    assign if8.InA      = in_a;
    assign if8.InB      = in_b;
    assign if8.Op       = op;
    assign if8.InLast   = in_last;
    assign if8.OutReady = out_ready;
    assign if2.InValid  = in_valid;
    assign if2.InA      = in_a;
    assign if2.InB      = in_b;
    assign if2.Op       = op;
    assign if2.InLast   = in_last;
    assign if2.OutReady = out_ready;

    logic_accum_unit #(.WIDTH(8), .CNT_W(8)) dut8 (.Clk(clk), .Rst(rst), .bus(if8.slave));
    logic_accum_unit #(.WIDTH(8), .CNT_W(2)) dut2 (.Clk(clk), .Rst(rst), .bus(if2.slave));

    always #5 clk = ~clk;

    wire [18:0] obs8 = {if8.InReady, if8.OutValid, if8.Out, if8.OutZero, if8.OutCount};
    wire [12:0] obs2 = {if2.InReady, if2.OutValid, if2.Out, if2.OutZero, if2.OutCount};

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;

    // Reference model state: pending result plus the beats of the open stream.
    logic       exp_valid;
    logic [7:0] exp_out;
    logic       exp_zero;
    logic [7:0] exp_cnt8;
    logic [1:0] exp_cnt2;
    logic [7:0] stream[$];
    logic       stream_and;

    function automatic logic [7:0] ref_bitwise(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_clear();
        exp_valid = 1'b0;
        exp_out   = 8'h00;
        exp_zero  = 1'b0;
        exp_cnt8  = 8'd0;
        exp_cnt2  = 2'd0;
        stream.delete();
        stream_and = 1'b0;
    endtask

    task automatic step();
        bit         acc;
        bit         fire;
        bit         newres;
        logic [7:0] res;
        int         len;
        acc    = in_valid && (!exp_valid || out_ready);
        fire   = exp_valid && out_ready;
        newres = 0;
        res    = 8'h00;
        len    = 0;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            if (stream.size() == 0) begin
                if (op == 3'b100 || op == 3'b101) begin
                    if (in_last) begin
                        newres = 1; res = in_a; len = 1;
                    end else begin
                        stream.push_back(in_a);
                        stream_and = (op == 3'b101);
                    end
                end else begin
                    newres = 1; res = ref_bitwise(op, in_a, in_b); len = 1;
                end
            end else begin
                stream.push_back(in_a);
                if (in_last) begin
                    res = stream_and ? 8'hFF : 8'h00;
                    foreach (stream[i]) res = stream_and ? (res & stream[i]) : (res | stream[i]);
                    len = stream.size();
                    stream.delete();
                    newres = 1;
                end
            end
        end
        if (newres) begin
            exp_valid = 1'b1;
            exp_out   = res;
            exp_zero  = (res == 8'h00);
            exp_cnt8  = 8'((len > 255) ? 255 : len);
            exp_cnt2  = 2'((len > 3) ? 3 : len);
        end else if (fire) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input bit l);
        in_valid = v; op = o; in_a = a; in_b = b; in_last = l;
    endtask

    task automatic test_reset();
        model_clear();
        n_cmp++;
        if (obs8 !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL reset dut8 got %h want %h", obs8, {1'b1, 1'b0, 8'h00, 1'b0, 8'h00});
        end
        n_cmp++;
        if (obs2 !== {1'b1, 1'b0, 8'h00, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL reset dut2 got %h want %h", obs2, {1'b1, 1'b0, 8'h00, 1'b0, 2'd0});
        end
        $display("reset: OutValid=%b Out=%h InReady=%b", if8.OutValid, if8.Out, if8.InReady);
    endtask

    task automatic test_bitwise();
        logic [2:0] ops[4] = '{3'd1, 3'd0, 3'd2, 3'd3};
        logic [7:0] as[4]  = '{8'hA0, 8'hF0, 8'hF0, 8'hF0};
        logic [7:0] bs[4]  = '{8'h05, 8'h3C, 8'h3C, 8'h3C};
        logic [7:0] want[4] = '{8'hA5, 8'h30, 8'hCC, 8'h03};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, ops[i], as[i], bs[i], 0);
            else       drive(0, 3'd0, 8'h00, 8'h00, 0);
            step();
            n_cmp++;
            if (obs8 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8}) begin
                n_fail++; $display("FAIL bitwise%0d dut8 got %h want %h", i, obs8, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8});
            end
            n_cmp++;
            if (obs2 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2}) begin
                n_fail++; $display("FAIL bitwise%0d dut2 got %h want %h", i, obs2, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2});
            end
            if (i < 4) begin
                n_cmp++;
                if (if8.Out !== want[i] || if8.OutCount !== 8'd1) begin
                    n_fail++; $display("FAIL bitwise_const%0d got %h/%0d want %h/1", i, if8.Out, if8.OutCount, want[i]);
                end
            end
            $display("bitwise %0d: Out=%h OutValid=%b OutCount=%0d", i, if8.Out, if8.OutValid, if8.OutCount);
        end
    endtask

    task automatic test_acc();
        logic [2:0] ops[7] = '{3'd4, 3'd4, 3'd4, 3'd5, 3'd1, 3'd1, 3'd0};
        logic [7:0] as[7]  = '{8'h01, 8'h02, 8'h80, 8'hFF, 8'h0F, 8'hF0, 8'h00};
        bit         ls[7]  = '{0, 0, 1, 0, 0, 1, 0};
        bit         vs[7]  = '{1, 1, 1, 1, 1, 1, 0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vs[i], ops[i], as[i], 8'h5A, ls[i]);
            step();
            n_cmp++;
            if (obs8 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8}) begin
                n_fail++; $display("FAIL acc%0d dut8 got %h want %h", i, obs8, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8});
            end
            n_cmp++;
            if (obs2 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2}) begin
                n_fail++; $display("FAIL acc%0d dut2 got %h want %h", i, obs2, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2});
            end
            $display("acc beat %0d: OutValid=%b Out=%h OutZero=%b OutCount=%0d", i, if8.OutValid, if8.Out, if8.OutZero, if8.OutCount);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1, 3'd2, 8'h5A, 8'h00, 0);
        step();
        drive(1, 3'd1, 8'h11, 8'h22, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (obs8 !== {1'b0, 1'b1, 8'h5A, 1'b0, 8'd1} || obs8 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8}) begin
                n_fail++; $display("FAIL hold%0d dut8 got %h want %h", i, obs8, {1'b0, 1'b1, 8'h5A, 1'b0, 8'd1});
            end
            n_cmp++;
            if (obs2 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2}) begin
                n_fail++; $display("FAIL hold%0d dut2 got %h want %h", i, obs2, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2});
            end
            $display("hold %0d: Out=%h InReady=%b", i, if8.Out, if8.InReady);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (if8.InReady !== 1'b1) begin
            n_fail++; $display("FAIL release_ready got %b want 1", if8.InReady);
        end
        step();
        n_cmp++;
        if (obs8 !== {1'b1, 1'b1, 8'h33, 1'b0, 8'd1} || obs8 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8}) begin
            n_fail++; $display("FAIL release dut8 got %h want %h", obs8, {1'b1, 1'b1, 8'h33, 1'b0, 8'd1});
        end
        $display("release: Out=%h OutValid=%b", if8.Out, if8.OutValid);
        drive(0, 3'd0, 8'h00, 8'h00, 0);
        step();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, (i == 0) ? 3'd4 : 3'($urandom_range(0, 7)), 8'(1 << (i % 8)) | 8'($urandom & 8'h11), 8'($urandom), i == 5);
            step();
            n_cmp++;
            if (obs8 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8}) begin
                n_fail++; $display("FAIL sat%0d dut8 got %h want %h", i, obs8, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8});
            end
            n_cmp++;
            if (obs2 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2}) begin
                n_fail++; $display("FAIL sat%0d dut2 got %h want %h", i, obs2, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2});
            end
            $display("sat beat %0d: Out=%h cnt8=%0d cnt2=%0d", i, if8.Out, if8.OutCount, if2.OutCount);
        end
        n_cmp++;
        if (if2.OutCount !== 2'd3 || if8.OutCount !== 8'd6) begin
            n_fail++; $display("FAIL sat_const got %0d/%0d want 3/6", if2.OutCount, if8.OutCount);
        end
        drive(0, 3'd0, 8'h00, 8'h00, 0);
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) in_a = 8'h00;
            out_ready = $urandom_range(0, 3) != 0;
            step();
            n_cmp++;
            if (obs8 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8}) begin
                n_fail++; $display("FAIL rand%0d dut8 got %h want %h", i, obs8, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8});
            end
            n_cmp++;
            if (obs2 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2}) begin
                n_fail++; $display("FAIL rand%0d dut2 got %h want %h", i, obs2, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2});
            end
            $display("rand %0d: v=%b op=%0d a=%h last=%b rdy=%b -> OutValid=%b Out=%h cnt=%0d",
                     i, in_valid, op, in_a, in_last, out_ready, if8.OutValid, if8.Out, if8.OutCount);
        end
        out_ready = 1'b1;
        drive(0, 3'd0, 8'h00, 8'h00, 0);
        step();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        drive(1, 3'd4, 8'h10, 8'h00, 0);
        step();
        drive(1, 3'd4, 8'h20, 8'h00, 0);
        step();
        drive(0, 3'd0, 8'h00, 8'h00, 0);
        #2 rst = 1'b1;
        #1;
        model_clear();
        n_cmp++;
        if (obs8 !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL midreset dut8 got %h want %h", obs8, {1'b1, 1'b0, 8'h00, 1'b0, 8'h00});
        end
        #2 rst = 1'b0;
        drive(1, 3'd1, 8'h00, 8'h00, 0);
        step();
        n_cmp++;
        if (obs8 !== {1'b1, 1'b1, 8'h00, 1'b1, 8'd1} || obs8 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt8}) begin
            n_fail++; $display("FAIL post_reset dut8 got %h want %h", obs8, {1'b1, 1'b1, 8'h00, 1'b1, 8'd1});
        end
        n_cmp++;
        if (obs2 !== {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2}) begin
            n_fail++; $display("FAIL post_reset dut2 got %h want %h", obs2, {!exp_valid | out_ready, exp_valid, exp_out, exp_zero, exp_cnt2});
        end
        $display("post-reset OR: Out=%h OutZero=%b OutCount=%0d", if8.Out, if8.OutZero, if8.OutCount);
        drive(0, 3'd0, 8'h00, 8'h00, 0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(0, 3'd0, 8'h00, 8'h00, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_bitwise();
        test_acc();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
